// File: rtl/msrv32_lsu_bus_ctrl.sv
// Load/store bus controller: IDLE -> BUSY (req until ack/timeout) -> RESP pulse; misaligned skips the bus.
// Min 3 cycles per access; upstream is stalled from request until the RESP cycle.
module msrv32_lsu_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  size_in,
    input  logic        load_unsigned_in,
    input  logic        load_req_in,
    input  logic        store_req_in,
    input  logic        dbus_ack_in,
    input  logic [31:0] dbus_rdata_in,
    output logic        dbus_req_out,
    output logic        dbus_we_out,
    output logic [31:0] dbus_addr_out,
    output logic [31:0] dbus_wdata_out,
    output logic [3:0]  dbus_wr_mask_out,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             uns_q;

    logic        req_any;
    logic        misaligned;
    logic        tmo_hit;
    logic [3:0]  wr_mask_fmt;
    logic [31:0] wr_data_fmt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;

    assign req_any    = load_req_in | store_req_in;
    assign misaligned = ((size_in == 2'b01) && addr_in[0]) ||
                        (size_in[1] && (addr_in[1:0] != 2'b00));
    assign tmo_hit    = TMO_EN && (tmo_cnt == CNT_MAX);
    assign stall_out  = ((state == IDLE) && req_any) || (state == BUSY);

    always_comb begin
        wr_mask_fmt = 4'b1111;
        wr_data_fmt = store_data_in;
        case (size_in)
            2'b00: begin
                wr_mask_fmt = 4'b0001 << addr_in[1:0];
                wr_data_fmt = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                wr_mask_fmt = 4'b0011 << {addr_in[1], 1'b0};
                wr_data_fmt = {2{store_data_in[15:0]}};
            end
            default: begin
                wr_mask_fmt = 4'b1111;
                wr_data_fmt = store_data_in;
            end
        endcase
    end

    // Lane selection uses the offset latched in IDLE, not the live address.
    always_comb begin
        rd_byte  = 8'(dbus_rdata_in >> {lane_q, 3'b000});
        rd_half  = 16'(dbus_rdata_in >> {lane_q[1], 4'b0000});
        load_fmt = dbus_rdata_in;
        case (size_q)
            2'b00:   load_fmt = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_fmt = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_fmt = dbus_rdata_in;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state            <= IDLE;
            tmo_cnt          <= '0;
            lane_q           <= 2'b00;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            dbus_req_out     <= 1'b0;
            dbus_we_out      <= 1'b0;
            dbus_addr_out    <= 32'd0;
            dbus_wdata_out   <= 32'd0;
            dbus_wr_mask_out <= 4'b0000;
            load_data_out    <= 32'd0;
            load_valid_out   <= 1'b0;
            misaligned_out   <= 1'b0;
            bus_error_out    <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        lane_q <= addr_in[1:0];
                        size_q <= size_in;
                        uns_q  <= load_unsigned_in;
                        if (misaligned) begin
                            state          <= RESP;
                            misaligned_out <= 1'b1;
                        end else begin
                            state            <= BUSY;
                            tmo_cnt          <= '0;
                            dbus_req_out     <= 1'b1;
                            dbus_we_out      <= store_req_in;
                            dbus_addr_out    <= {addr_in[31:2], 2'b00};
                            dbus_wdata_out   <= wr_data_fmt;
                            dbus_wr_mask_out <= store_req_in ? wr_mask_fmt : 4'b0000;
                        end
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (dbus_ack_in) begin
                        state            <= RESP;
                        dbus_req_out     <= 1'b0;
                        dbus_we_out      <= 1'b0;
                        dbus_wr_mask_out <= 4'b0000;
                        if (!dbus_we_out) begin
                            load_data_out  <= load_fmt;
                            load_valid_out <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state            <= RESP;
                        dbus_req_out     <= 1'b0;
                        dbus_we_out      <= 1'b0;
                        dbus_wr_mask_out <= 4'b0000;
                        bus_error_out    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_lsu_bus_ctrl.sv
// Randomised scoreboard bench for msrv32_lsu_bus_ctrl with a byte-level reference model.
module tb_msrv32_lsu_bus_ctrl;

    localparam int TMO = 15;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [1:0]  size_in;
    logic        load_unsigned_in;
    logic        load_req_in;
    logic        store_req_in;
    logic        dbus_ack_in;
    logic [31:0] dbus_rdata_in;
    logic        dbus_req_out;
    logic        dbus_we_out;
    logic [31:0] dbus_addr_out;
    logic [31:0] dbus_wdata_out;
    logic [3:0]  dbus_wr_mask_out;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        misaligned_out;
    logic        bus_error_out;

    always #5 clk_in = ~clk_in;

    msrv32_lsu_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .addr_in(addr_in),
        .store_data_in(store_data_in), .size_in(size_in),
        .load_unsigned_in(load_unsigned_in), .load_req_in(load_req_in),
        .store_req_in(store_req_in), .dbus_ack_in(dbus_ack_in),
        .dbus_rdata_in(dbus_rdata_in), .dbus_req_out(dbus_req_out),
        .dbus_we_out(dbus_we_out), .dbus_addr_out(dbus_addr_out),
        .dbus_wdata_out(dbus_wdata_out), .dbus_wr_mask_out(dbus_wr_mask_out),
        .stall_out(stall_out), .load_data_out(load_data_out),
        .load_valid_out(load_valid_out), .misaligned_out(misaligned_out),
        .bus_error_out(bus_error_out)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        longint      cyc;
    } bus_exp_t;

    typedef struct {
        logic [2:0]  flags;   // {load_valid, misaligned, bus_error}
        logic [31:0] data;
        longint      cyc;
    } rsp_exp_t;

    bus_exp_t    bus_q[$];
    rsp_exp_t    rsp_q[$];
    int          total = 0;
    int          bad = 0;
    longint      cyc = 0;
    logic [31:0] last_load = 32'd0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares bus activity and response pulses against the queues.
    bus_exp_t mb;
    rsp_exp_t mr;
    always @(negedge clk_in) begin
        if (reset_n_in) begin
            if (dbus_req_out) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_req", {63'd0, dbus_req_out}, 64'd0);
                end else begin
                    mb = bus_q[0];
                    chk("bus_addr", {32'd0, dbus_addr_out}, {32'd0, mb.addr});
                    chk("bus_we", {63'd0, dbus_we_out}, {63'd0, mb.we});
                    chk("bus_mask", {60'd0, dbus_wr_mask_out}, {60'd0, mb.mask});
                    if (mb.we) chk("bus_wdata", {32'd0, dbus_wdata_out}, {32'd0, mb.wdata});
                    if (dbus_ack_in) begin
                        chk("bus_ack_cycle", cyc, mb.cyc);
                        void'(bus_q.pop_front());
                    end
                end
            end
            if (load_valid_out || misaligned_out || bus_error_out) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {61'd0, load_valid_out, misaligned_out, bus_error_out}, 64'd0);
                end else begin
                    mr = rsp_q.pop_front();
                    chk("rsp_flags", {61'd0, load_valid_out, misaligned_out, bus_error_out},
                        {61'd0, mr.flags});
                    chk("rsp_load_data", {32'd0, load_data_out}, {32'd0, mr.data});
                    chk("rsp_cycle", cyc, mr.cyc);
                    // A timed-out transfer never sees ack; retire its bus entry here.
                    if (bus_error_out && bus_q.size() != 0) void'(bus_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            load_req_in   = 1'b0;
            store_req_in  = 1'b0;
            dbus_ack_in   = 1'($urandom_range(0, 1));
            dbus_rdata_in = $urandom;
        end
    endtask

    // One memory instruction: model computes expectations, then the request is
    // held until stall drops (RESP), acking after k wait states unless tmo.
    task automatic do_instr(input bit ld, input bit st, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] sz, input bit uns,
                            input logic [31:0] rd, input int k, input bit tmo);
        int          nb, off, e, c, nst;
        bit          mis, wr, normal, ack;
        logic [31:0] v, w;
        logic [3:0]  m;
        bus_exp_t    b;
        rsp_exp_t    r;

        nb     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        off    = int'(a[1:0]);
        mis    = (off % nb) != 0;
        wr     = st;
        normal = !mis && !tmo;
        e      = mis ? 1 : (tmo ? TMO + 2 : 2 + k);

        @(posedge clk_in); #1;
        load_req_in      = ld;
        store_req_in     = st;
        addr_in          = a;
        store_data_in    = d;
        size_in          = sz;
        load_unsigned_in = uns;
        dbus_ack_in      = 1'($urandom_range(0, 1));
        dbus_rdata_in    = $urandom;

        if (!mis) begin
            for (int i = 0; i < 4; i++) begin
                m[i]         = wr && (i >= off) && (i < off + nb);
                w[8*i +: 8]  = d[8*(i % nb) +: 8];
            end
            b.addr  = {a[31:2], 2'b00};
            b.we    = wr;
            b.mask  = m;
            b.wdata = w;
            b.cyc   = cyc + 1 + k;
            bus_q.push_back(b);
        end
        r.cyc = cyc + e;
        if (mis) begin
            r.flags = 3'b010;
            r.data  = last_load;
            rsp_q.push_back(r);
        end else if (tmo) begin
            r.flags = 3'b001;
            r.data  = last_load;
            rsp_q.push_back(r);
        end else if (!wr) begin
            v = 32'd0;
            for (int j = 0; j < nb; j++) v[8*j +: 8] = rd[8*(off + j) +: 8];
            if (!uns && nb < 4 && v[8*nb - 1])
                for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
            last_load = v;
            r.flags   = 3'b100;
            r.data    = v;
            rsp_q.push_back(r);
        end

        c   = 0;
        nst = 0;
        forever begin
            @(negedge clk_in);
            if (!stall_out) break;
            nst++;
            if (nst > 200) begin
                chk("stall_bound", {63'd0, stall_out}, 64'd0);
                break;
            end
            @(posedge clk_in); #1;
            c++;
            ack = (normal && c == 1 + k) || (c == e && $urandom_range(0, 1) == 1);
            dbus_ack_in   = ack;
            dbus_rdata_in = (normal && c == 1 + k) ? rd : $urandom;
        end
        chk("stall_cycles", nst, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n_in       = 1'b1;
        addr_in          = 32'd0;
        store_data_in    = 32'd0;
        size_in          = 2'b00;
        load_unsigned_in = 1'b0;
        load_req_in      = 1'b0;
        store_req_in     = 1'b0;
        dbus_ack_in      = 1'b0;
        dbus_rdata_in    = 32'd0;
        #2 reset_n_in = 1'b0;
        #1;
        chk("rst_req", {63'd0, dbus_req_out}, 64'd0);
        chk("rst_we", {63'd0, dbus_we_out}, 64'd0);
        chk("rst_addr", {32'd0, dbus_addr_out}, 64'd0);
        chk("rst_wdata", {32'd0, dbus_wdata_out}, 64'd0);
        chk("rst_mask", {60'd0, dbus_wr_mask_out}, 64'd0);
        chk("rst_stall", {63'd0, stall_out}, 64'd0);
        chk("rst_load_data", {32'd0, load_data_out}, 64'd0);
        chk("rst_flags", {61'd0, load_valid_out, misaligned_out, bus_error_out}, 64'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in) reset_n_in = 1'b1;

        // Reset while BUSY: request must drop at once, no response afterwards.
        @(posedge clk_in); #1;
        load_req_in = 1'b1;
        addr_in     = 32'h0000_6000;
        size_in     = 2'b10;
        @(posedge clk_in); #1;
        chk("busy_req", {63'd0, dbus_req_out}, 64'd1);
        #2 reset_n_in = 1'b0;
        #1;
        chk("reset_req_drop", {63'd0, dbus_req_out}, 64'd0);
        load_req_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in) reset_n_in = 1'b1;
        idle(3);

        do_instr(1, 0, 32'h0000_1004, 32'd0,        2'b10, 0, 32'h8000_00FF, 0, 0);
        do_instr(1, 0, 32'h0000_1003, 32'd0,        2'b00, 0, 32'h80AA_BBCC, 0, 0);
        do_instr(1, 0, 32'h0000_1003, 32'd0,        2'b00, 1, 32'h80AA_BBCC, 0, 0);
        do_instr(0, 1, 32'h0000_2002, 32'h1234_5678, 2'b01, 0, 32'd0,        3, 0);
        do_instr(1, 0, 32'h0000_3001, 32'd0,        2'b10, 0, 32'd0,        0, 0);
        do_instr(1, 1, 32'h0000_4008, 32'hCAFE_F00D, 2'b10, 0, 32'h1111_2222, 1, 0);
        do_instr(1, 0, 32'h0000_5000, 32'd0,        2'b10, 0, 32'd0,        0, 1);
        do_instr(1, 0, 32'h0000_5004, 32'd0,        2'b01, 0, 32'hABCD_8765, 14, 0);
        do_instr(1, 0, 32'h0000_5006, 32'd0,        2'b01, 1, 32'h9876_1234, 15, 0);
        do_instr(0, 1, 32'h0000_7001, 32'hA5A5_5A5A, 2'b01, 0, 32'd0,        0, 0);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            do_instr(sel != 1, sel != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4),
                     $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msrv32_lsu_bus_ctrl.md
# msrv32_lsu_bus_ctrl

Load/store bus controller for the MSRV32 core, sitting directly downstream of `msrv32_reg_block_2`. It consumes the registered effective address (`iadder_out_reg_out`), store data (`rs2_reg_out`), load size and load-unsigned fields. It runs a request/acknowledge transaction on the data bus and stalls the pipeline until the access completes. It also returns aligned, sign- or zero-extended load data to the write-back mux.

## Interface
- `TIMEOUT_CYCLES`, default 15: number of BUSY cycles without ack before a bus error is raised; 0 disables the timeout.
- `clk_in` input 1: core clock; all state updates on rising edge.
- `reset_n_in` input 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `addr_in` input 32: effective address from `iadder_out_reg_out`.
- `store_data_in` input 32: from `rs2_reg_out`.
- `size_in` input 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `load_unsigned_in` input 1: 1 = zero-extend, 0 = sign-extend.
- `load_req_in` input 1: current instruction is a load.
- `store_req_in` input 1: current instruction is a store; it takes precedence if both inputs are high.
- `dbus_ack_in` input 1: slave completes the transfer (accepted in BUSY only).
- `dbus_rdata_in` input 32: read data, valid with `dbus_ack_in`.
- `dbus_req_out` output 1: transfer request.
- `dbus_we_out` output 1: 1 = write.
- `dbus_addr_out` output 32: word-aligned address, {addr[31:2], 2'b00}.
- `dbus_wdata_out` output 32: lane-replicated store data.
- `dbus_wr_mask_out` output 4: byte enables (0000 on reads).
- `stall_out` output 1: freeze the upstream pipeline register.
- `load_data_out` output 32: formatted load result.
- `load_valid_out` output 1: one-cycle pulse; `load_data_out` is valid.
- `misaligned_out` output 1: one-cycle pulse on a misaligned access.
- `bus_error_out` output 1: one-cycle pulse on timeout.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE, with a request present:** latch address, size, unsigned flag, direction and formatted write data.
  - Aligned access: go to BUSY.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0): go to RESP with the misaligned flag set; no bus transfer is issued.
- **IDLE, no request:** stay in IDLE.
- **BUSY:**
  - `dbus_req_out`=1 and all `dbus_*` outputs are driven from the latched registers, stable until ack.
  - On `dbus_ack_in`=1: capture the formatted rdata (loads), go to RESP.
  - On timeout: go to RESP with the error flag set.
- **RESP:** one cycle only.
  - `load_valid_out`=1 for a successful load.
  - `misaligned_out` or `bus_error_out`=1 if the corresponding flag is set.
  - Always returns to IDLE. Requests seen in RESP are NOT accepted, because they belong to the same instruction, still held upstream.
- **`stall_out` is combinational:** 1 in IDLE when a request is present, and 1 throughout BUSY. It is 0 in RESP and in IDLE without a request.
- **Write mask:**
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << {addr[1],1'b0}.
  - Word: 1111.
- **Write data:**
  - Byte: {4{d[7:0]}}.
  - Half: {2{d[15:0]}}.
  - Word: d.
- **Load formatting:**
  - Byte lane: rdata >> 8·addr[1:0], then bits [7:0] are extended.
  - Half lane: rdata >> 16·addr[1], then bits [15:0] are extended.
  - Extension is zero or sign per `load_unsigned_in`.
- **`load_data_out` holding:** holds its value until the next successful load; not cleared by stores or errors.
- **Timeout counter:**
  - Width $clog2(TIMEOUT_CYCLES+1); cleared on entry to BUSY.
  - Increments every BUSY cycle without ack.
  - Timeout fires when the count reaches TIMEOUT_CYCLES.
  - Ack in the same cycle as the timeout wins: normal completion.
- **Stray ack:** `dbus_ack_in` in IDLE or RESP is ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0.
- **Reset mid-transaction:** `dbus_req_out` drops immediately (asynchronous); no RESP pulse follows.
- **Zero-wait access**, request present in cycle N (IDLE):
  - BUSY in cycle N+1, with `dbus_req_out`=1.
  - Ack in cycle N+1.
  - RESP in cycle N+2.
  - `stall_out`=1 in N and N+1, 0 in N+2.
  - Minimum 3 cycles per memory instruction.
- **k wait states:** RESP in cycle N+2+k.
- **Misaligned access:** RESP (with `misaligned_out`) in cycle N+1; `stall_out`=1 only in cycle N.
- **Timeout:** `bus_error_out` pulses in cycle N+2+TIMEOUT_CYCLES.
- **Back-to-back memory instructions:** the next request is evaluated in the IDLE cycle after RESP.

## Test plan
- Reset: hold `reset_n_in`=0 → all outputs 0. Then assert `reset_n_in`=0 while in BUSY → `dbus_req_out` falls in the same cycle.
- Word load, addr=0x0000_1004, zero-wait ack, rdata=0x8000_00FF → `dbus_addr_out`=0x1004, `dbus_wr_mask_out`=0000. Expect `load_valid_out` in N+2 with `load_data_out`=0x8000_00FF, and stall high for exactly 2 cycles.
- Signed byte load, addr=0x1003, rdata=0x80AA_BBCC, unsigned=0 → 0xFFFF_FF80. Repeat with unsigned=1 → 0x0000_0080.
- Half store, addr=0x2002, data=0x1234_5678, ack after 3 wait states → `dbus_wdata_out`=0x5678_5678, mask=1100, `dbus_we_out`=1, stall high for 5 cycles, no `load_valid_out`.
- Misaligned word load, addr=0x3001 → no `dbus_req_out`, `misaligned_out` pulse in N+1, stall 1 cycle. Also: load and store both high → write is issued.
- Timeout with TIMEOUT_CYCLES=15 and no ack → `bus_error_out` in N+17, FSM back in IDLE. Also: ack on the 15th BUSY cycle → normal completion, no error.
